// File: rtl/stall_ctrl_if.sv
// Hazard-control signals exchanged between the pipeline datapath (master)
// and the stall controller (slave).
interface stall_ctrl_if;
    // Decode-stage sources and their use deadlines
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic [1:0]  tuse_rs;
    logic [1:0]  tuse_rt;
    // Producers in E and M
    logic [4:0]  a3_E;
    logic [4:0]  a3_M;
    logic [1:0]  tnew_E;
    logic [1:0]  tnew_M;
    // Multiply/divide unit requests
    logic        md_start_E;
    logic        md_div_E;
    logic        md_use_D;
    // Pipeline controls and status
    logic        pc_en;
    logic        if2id_en;
    logic        id2ex_clr;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt;

    modport master (
        output rs_D, rt_D, tuse_rs, tuse_rt,
        output a3_E, a3_M, tnew_E, tnew_M,
        output md_start_E, md_div_E, md_use_D,
        input  pc_en, if2id_en, id2ex_clr, md_busy, md_cnt, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs, tuse_rt,
        input  a3_E, a3_M, tnew_E, tnew_M,
        input  md_start_E, md_div_E, md_use_D,
        output pc_en, if2id_en, id2ex_clr, md_busy, md_cnt, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data-hazard detection, multiply/divide
// busy tracking and a free-running stall-cycle counter.
module stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    stall_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    state_t      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic stall_rs;
    logic stall_rt;
    logic md_stall;
    logic stall;

    // A source stalls when a younger-than-needed result targets it; r0 never stalls.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == a3_e) && (tnew_e > tuse);
        hit_m = (src == a3_m) && (tnew_m > tuse);
        return (src != 5'd0) && (hit_e || hit_m);
    endfunction

    assign stall_rs = src_hazard(bus.rs_D, bus.tuse_rs, bus.a3_E, bus.tnew_E,
                                 bus.a3_M, bus.tnew_M);
    assign stall_rt = src_hazard(bus.rt_D, bus.tuse_rt, bus.a3_E, bus.tnew_E,
                                 bus.a3_M, bus.tnew_M);

    // md_start_E counts as busy so D cannot slip past an op that is just launching.
    assign md_stall = bus.md_use_D && ((state_q == BUSY) || bus.md_start_E);
    assign stall    = stall_rs || stall_rt || md_stall;

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.md_start_E) begin
                    state_d  = BUSY;
                    md_cnt_d = bus.md_div_E ? DIV_LOAD : MULT_LOAD;
                end else begin
                    md_cnt_d = 4'd0;
                end
            end
            BUSY: begin
                // A new start while busy is ignored; the count simply runs out.
                if (md_cnt_q <= 4'd1) begin
                    state_d  = IDLE;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en     = !stall;
    assign bus.if2id_en  = !stall;
    assign bus.id2ex_clr = stall;
    assign bus.md_busy   = (state_q == BUSY);
    assign bus.md_cnt    = md_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomised and directed bench for stall_ctrl against a timeline-based model
// of the multiply/divide busy window and the hazard rules.
module tb_stall_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stall_ctrl_if bus();

    stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    longint      cyc      = 0;
    longint      busy_end = 0;   // first cycle index at which the MD unit is free again
    logic [31:0] m_stall_cnt = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit src_stall(input int src, input int tuse);
        int a3e, a3m, tne, tnm;
        a3e = int'(bus.a3_E);
        a3m = int'(bus.a3_M);
        tne = int'(bus.tnew_E);
        tnm = int'(bus.tnew_M);
        if (src == 0) return 1'b0;
        return ((src == a3e) && (tne > tuse)) || ((src == a3m) && (tnm > tuse));
    endfunction

    task automatic clear_inputs();
        bus.rs_D = 5'd0;  bus.rt_D = 5'd0;
        bus.tuse_rs = 2'd3; bus.tuse_rt = 2'd3;
        bus.a3_E = 5'd0;  bus.a3_M = 5'd0;
        bus.tnew_E = 2'd0; bus.tnew_M = 2'd0;
        bus.md_start_E = 1'b0; bus.md_div_E = 1'b0; bus.md_use_D = 1'b0;
    endtask

    // One clock: compare at negedge, advance the model at posedge, return 1 time unit later.
    task automatic cycle();
        bit          busy;
        bit          st;
        logic [31:0] exp_cnt;
        @(negedge clk);
        busy = (cyc < busy_end);
        st = src_stall(int'(bus.rs_D), int'(bus.tuse_rs))
          || src_stall(int'(bus.rt_D), int'(bus.tuse_rt))
          || (bus.md_use_D && (busy || bus.md_start_E));
        exp_cnt = busy ? 32'(busy_end - cyc) : 32'd0;
        check_eq("pc_en",     {31'd0, bus.pc_en},     {31'd0, !st});
        check_eq("if2id_en",  {31'd0, bus.if2id_en},  {31'd0, !st});
        check_eq("id2ex_clr", {31'd0, bus.id2ex_clr}, {31'd0, st});
        check_eq("md_busy",   {31'd0, bus.md_busy},   {31'd0, busy});
        check_eq("md_cnt",    {28'd0, bus.md_cnt},    exp_cnt);
        check_eq("stall_cnt", bus.stall_cnt,          m_stall_cnt);
        @(posedge clk);
        if (reset) begin
            busy_end    = 0;
            m_stall_cnt = 32'd0;
        end else begin
            if (st) m_stall_cnt = m_stall_cnt + 32'd1;
            if (!busy && bus.md_start_E)
                busy_end = cyc + 1 + (bus.md_div_E ? 10 : 5);
        end
        cyc++;
        #1;
    endtask

    task automatic reset_cycle();
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int busy_seen;
        reset = 1'b1;
        clear_inputs();
        // First edge establishes the reset state; nothing defined to compare before it.
        @(posedge clk);
        cyc = 1;
        #1;
        reset = 1'b0;
        check_eq("reset_md_busy",   {31'd0, bus.md_busy}, 32'd0);
        check_eq("reset_md_cnt",    {28'd0, bus.md_cnt},  32'd0);
        check_eq("reset_stall_cnt", bus.stall_cnt,        32'd0);

        // rs hazard against E
        reset_cycle();
        bus.rs_D = 5'd5; bus.a3_E = 5'd5; bus.tnew_E = 2'd2; bus.tuse_rs = 2'd1;
        #1;
        check_eq("raw_pc_en",     {31'd0, bus.pc_en},     32'd0);
        check_eq("raw_if2id_en",  {31'd0, bus.if2id_en},  32'd0);
        check_eq("raw_id2ex_clr", {31'd0, bus.id2ex_clr}, 32'd1);
        cycle();
        check_eq("raw_stall_cnt", bus.stall_cnt, 32'd1);

        // r0 never stalls
        clear_inputs();
        bus.rs_D = 5'd0; bus.a3_E = 5'd0; bus.tnew_E = 2'd2; bus.tuse_rs = 2'd0;
        #1;
        check_eq("r0_pc_en",     {31'd0, bus.pc_en},     32'd1);
        check_eq("r0_id2ex_clr", {31'd0, bus.id2ex_clr}, 32'd0);
        cycle();

        // mult: 5 busy cycles, 6 stall cycles with md_use_D held
        reset_cycle();
        bus.md_use_D = 1'b1; bus.md_start_E = 1'b1; bus.md_div_E = 1'b0;
        cycle();
        bus.md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("mult_busy", {31'd0, bus.md_busy}, 32'd1);
            check_eq("mult_cnt",  {28'd0, bus.md_cnt},  32'(5 - i));
            cycle();
        end
        check_eq("mult_done_busy", {31'd0, bus.md_busy}, 32'd0);
        check_eq("mult_done_cnt",  {28'd0, bus.md_cnt},  32'd0);
        check_eq("mult_stalls",    bus.stall_cnt,        32'd6);
        cycle();

        // div with a second start at md_cnt=7: no reload
        reset_cycle();
        bus.md_start_E = 1'b1; bus.md_div_E = 1'b1;
        cycle();
        busy_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.md_busy) busy_seen++;
            if (i == 3) check_eq("div_cnt_at_pulse", {28'd0, bus.md_cnt}, 32'd7);
            bus.md_start_E = (i == 3);
            cycle();
        end
        check_eq("div_busy_cycles", 32'(busy_seen), 32'd10);

        // reset in the middle of a divide
        reset_cycle();
        bus.md_use_D = 1'b1; bus.md_start_E = 1'b1; bus.md_div_E = 1'b1;
        cycle();
        bus.md_start_E = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_eq("mid_cnt", {28'd0, bus.md_cnt}, 32'd6);
        reset = 1'b1;
        bus.md_start_E = 1'b1;
        cycle();
        reset = 1'b0;
        bus.md_start_E = 1'b0;
        check_eq("rst_mid_busy",      {31'd0, bus.md_busy}, 32'd0);
        check_eq("rst_mid_cnt",       {28'd0, bus.md_cnt},  32'd0);
        check_eq("rst_mid_stall_cnt", bus.stall_cnt,        32'd0);
        clear_inputs();
        cycle();

        // stall counter wrap
        bus.rs_D = 5'd5; bus.a3_E = 5'd5; bus.tnew_E = 2'd2; bus.tuse_rs = 2'd1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_stall_cnt = 32'hFFFF_FFFF;
        cycle();
        check_eq("wrap_stall_cnt", bus.stall_cnt, 32'd0);
        clear_inputs();
        cycle();

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            bus.rs_D       = 5'($urandom_range(0, 3));
            bus.rt_D       = 5'($urandom_range(0, 3));
            bus.a3_E       = 5'($urandom_range(0, 3));
            bus.a3_M       = 5'($urandom_range(0, 3));
            bus.tuse_rs    = 2'($urandom_range(0, 3));
            bus.tuse_rt    = 2'($urandom_range(0, 3));
            bus.tnew_E     = 2'($urandom_range(0, 3));
            bus.tnew_M     = 2'($urandom_range(0, 3));
            bus.md_start_E = ($urandom_range(0, 7) == 0);
            bus.md_div_E   = 1'($urandom_range(0, 1));
            bus.md_use_D   = 1'($urandom_range(0, 1));
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
